// File: rtl/div_iter_unit_pkg.sv
// Shared types and helpers for the iterative divider.
package div_iter_unit_pkg;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_DONE = 2'd2
  } div_state_e;

  // Step counter width; one spare bit so XLEN-1 always fits.
  function automatic int div_cnt_w(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/div_iter_unit_step.sv
// One restoring-division iteration: trial subtract of the divisor from the
// partial remainder extended with the next dividend bit.
module div_iter_unit_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-2:0] a_out,
  output logic            q_bit
);

  logic [XLEN:0] trial;

  // Keep the difference when it does not borrow, otherwise restore the shifted remainder.
  always_comb begin
    trial   = {rem_in, a_in[XLEN-1]} - {1'b0, b_in};
    q_bit   = ~trial[XLEN];
    rem_out = q_bit ? trial[XLEN-1:0] : {rem_in[XLEN-2:0], a_in[XLEN-1]};
    a_out   = a_in[XLEN-2:0];
  end

endmodule

// File: rtl/div_iter_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU and their W forms.
// Quotient and remainder are produced together behind a valid/ready pair.
//
//  state        | meaning
//  -------------+-----------------------------------------------------------
//  DIV_ST_IDLE  | waiting for an op; in_ready high
//  DIV_ST_CALC  | one restoring step per cycle, count 0..N-1
//  DIV_ST_DONE  | out_valid high, results held until out_ready
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter bit WORD_EN = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            div_signed,
  input  logic            word_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            busy
);

  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = div_cnt_w(XLEN);

  div_state_e state, state_nxt;

  logic             accept;
  logic             word_sel;
  logic [XLEN-1:0]  a_eff, b_eff, abs_a, abs_b, a_load, min_neg;
  logic             sign_a, sign_b, b_zero, ovf;

  logic [XLEN-1:0]  rem_q, a_q, b_q;
  logic [CNT_W-1:0] count, n_last;
  logic             neg_q, neg_r, word_q;

  logic [XLEN-1:0]  step_rem;
  logic [XLEN-2:0]  step_a_sh;
  logic             step_qbit;
  logic [XLEN-1:0]  step_a;

  // Optional negate, then sign-extend from the half-word for W forms.
  function automatic logic [XLEN-1:0] fixup(input logic [XLEN-1:0] v,
                                            input logic neg,
                                            input logic word);
    logic [XLEN-1:0] t;
    t = neg ? -v : v;
    if (word) t = {{HALF{t[HALF-1]}}, t[HALF-1:0]};
    return t;
  endfunction

  assign in_ready  = (state == DIV_ST_IDLE);
  assign out_valid = (state == DIV_ST_DONE);
  assign busy      = (state != DIV_ST_IDLE);
  assign accept    = in_valid && in_ready && !flush;

  // Effective operands, magnitudes and the two short-circuit cases.
  always_comb begin
    word_sel = WORD_EN & word_op;
    if (word_sel) begin
      a_eff   = div_signed ? {{HALF{dividend[HALF-1]}}, dividend[HALF-1:0]}
                           : {{HALF{1'b0}}, dividend[HALF-1:0]};
      b_eff   = div_signed ? {{HALF{divisor[HALF-1]}}, divisor[HALF-1:0]}
                           : {{HALF{1'b0}}, divisor[HALF-1:0]};
      min_neg = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end else begin
      a_eff   = dividend;
      b_eff   = divisor;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    sign_a = div_signed & a_eff[XLEN-1];
    sign_b = div_signed & b_eff[XLEN-1];
    abs_a  = sign_a ? -a_eff : a_eff;
    abs_b  = sign_b ? -b_eff : b_eff;
    b_zero = (b_eff == '0);
    ovf    = div_signed & (a_eff == min_neg) & (b_eff == '1);
    // W forms run only HALF steps, so the dividend starts in the upper half.
    a_load = word_sel ? {abs_a[HALF-1:0], {HALF{1'b0}}} : abs_a;
  end

  div_iter_unit_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .a_in    (a_q),
    .b_in    (b_q),
    .rem_out (step_rem),
    .a_out   (step_a_sh),
    .q_bit   (step_qbit)
  );

  assign step_a = {step_a_sh, step_qbit};

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= DIV_ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      DIV_ST_IDLE: if (accept) state_nxt = (b_zero || ovf) ? DIV_ST_DONE : DIV_ST_CALC;
      DIV_ST_CALC: if (count == n_last) state_nxt = DIV_ST_DONE;
      DIV_ST_DONE: if (out_ready) state_nxt = DIV_ST_IDLE;
      default:     state_nxt = DIV_ST_IDLE;
    endcase
    if (flush) state_nxt = DIV_ST_IDLE;
  end

  // Operand latch, iteration registers and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      count     <= '0;
      n_last    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      word_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        DIV_ST_IDLE: begin
          if (accept) begin
            rem_q  <= '0;
            a_q    <= a_load;
            b_q    <= abs_b;
            count  <= '0;
            n_last <= word_sel ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            word_q <= word_sel;
            if (b_zero) begin
              quotient  <= '1;
              remainder <= fixup(a_eff, 1'b0, word_sel);
            end else if (ovf) begin
              quotient  <= fixup(a_eff, 1'b0, word_sel);
              remainder <= '0;
            end
          end
        end
        DIV_ST_CALC: begin
          if (!flush) begin
            rem_q <= step_rem;
            a_q   <= step_a;
            count <= count + CNT_W'(1);
            if (count == n_last) begin
              quotient  <= fixup(step_a, neg_q, word_q);
              remainder <= fixup(step_rem, neg_r, word_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
